// File: rtl/fetch_queue_front.sv
// fetch_queue_front: RV32 fetch front end between instruction memory and decode.
//
// Generates the PC, issues one instruction-memory request at a time, buffers the
// fetched {pc, instr} pairs in a QDEPTH-entry circular queue and presents the head
// entry (plus decoded register/opcode fields) to decode with a valid/stall handshake.
// Redirect and flush clear the queue and squash any in-flight fetch.
//
// Ports:
//   fq_clk, fq_rst          clock, asynchronous active-low reset
//   fq_o_imem_req/addr      memory request valid / address (held until ack)
//   fq_i_imem_ack/instr     memory response valid / data
//   fq_i_change_pc          redirect to fq_i_alu_pc_value
//   fq_i_flush              clear queue and squash in-flight fetch, PC unchanged
//   fq_i_stall              decode cannot accept the head this cycle
//   fq_o_valid/instr/pc     head entry
//   fq_o_opcode..addr_rs2   instruction fields of the head entry
//   fq_o_count              number of occupied queue entries
module fetch_queue_front #(
  parameter int unsigned          IWIDTH   = 32,
  parameter int unsigned          PC_WIDTH = 32,
  parameter int unsigned          QDEPTH   = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic                      fq_clk,
  input  logic                      fq_rst,
  output logic                      fq_o_imem_req,
  output logic [PC_WIDTH-1:0]       fq_o_imem_addr,
  input  logic                      fq_i_imem_ack,
  input  logic [IWIDTH-1:0]         fq_i_imem_instr,
  input  logic                      fq_i_change_pc,
  input  logic [PC_WIDTH-1:0]       fq_i_alu_pc_value,
  input  logic                      fq_i_flush,
  input  logic                      fq_i_stall,
  output logic                      fq_o_valid,
  output logic [IWIDTH-1:0]         fq_o_instr,
  output logic [PC_WIDTH-1:0]       fq_o_pc,
  output logic [6:0]                fq_o_opcode,
  output logic [4:0]                fq_o_addr_rd,
  output logic [2:0]                fq_o_funct3,
  output logic [4:0]                fq_o_addr_rs1,
  output logic [4:0]                fq_o_addr_rs2,
  output logic [$clog2(QDEPTH):0]   fq_o_count
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(QDEPTH);

  typedef enum logic {StIdle, StWait} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                squash_q, squash_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  logic [PC_WIDTH-1:0] q_pc    [QDEPTH];
  logic [IWIDTH-1:0]   q_instr [QDEPTH];

  logic kill, push, pop, valid;

  // Redirect and flush share all queue/squash effects; only the PC update differs.
  assign kill  = fq_i_change_pc | fq_i_flush;
  assign valid = (count_q != '0);
  // A full-queue push cannot happen given the issue credit; it is dropped if it does.
  assign push  = (state_q == StWait) & fq_i_imem_ack & ~squash_q & ~kill &
                 (count_q != DepthCnt);
  assign pop   = valid & ~fq_i_stall & ~kill;

  // Request FSM
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    squash_d = squash_q;
    case (state_q)
      StIdle: begin
        if (!kill && (count_q != DepthCnt)) begin
          state_d  = StWait;
          addr_d   = pc_q;
          squash_d = 1'b0;
        end
      end
      StWait: begin
        if (fq_i_imem_ack) begin
          state_d  = StIdle;
          squash_d = 1'b0;
        end else if (kill) begin
          // Keep the old request up until memory answers, then discard the answer.
          squash_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // PC and queue bookkeeping
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fq_i_change_pc) begin
      pc_d = fq_i_alu_pc_value;
    end else if (push) begin
      pc_d = pc_q + PC_WIDTH'(PC_STEP);
    end
    if (kill) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge fq_clk or negedge fq_rst) begin
    if (!fq_rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      squash_q <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      squash_q <= squash_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage needs no reset: outputs are gated by valid.
  always_ff @(posedge fq_clk) begin
    if (push) begin
      q_pc[wr_ptr_q]    <= addr_q;
      q_instr[wr_ptr_q] <= fq_i_imem_instr;
    end
  end

  assign fq_o_imem_req  = (state_q == StWait);
  assign fq_o_imem_addr = addr_q;
  assign fq_o_valid     = valid;
  assign fq_o_instr     = valid ? q_instr[rd_ptr_q] : '0;
  assign fq_o_pc        = valid ? q_pc[rd_ptr_q] : '0;
  assign fq_o_opcode    = fq_o_instr[6:0];
  assign fq_o_addr_rd   = fq_o_instr[11:7];
  assign fq_o_funct3    = fq_o_instr[14:12];
  assign fq_o_addr_rs1  = fq_o_instr[19:15];
  assign fq_o_addr_rs2  = fq_o_instr[24:20];
  assign fq_o_count     = count_q;

endmodule

// File: tb/tb_fetch_queue_front.sv
module tb_fetch_queue_front;

  localparam int QD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ack, chg, flush, stall;
  logic [31:0] instr_in, tgt;
  logic        req, valid;
  logic [31:0] addr, instr_o, pc_o;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [2:0]  cnt;

  // Second instance with a wrapping reset PC
  logic        w_ack, w_stall, w_zero;
  logic [31:0] w_instr, w_zero32;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr_o, w_pc_o;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [2:0]  w_cnt;

  fetch_queue_front dut (
    .fq_clk(clk), .fq_rst(rst_n),
    .fq_o_imem_req(req), .fq_o_imem_addr(addr),
    .fq_i_imem_ack(ack), .fq_i_imem_instr(instr_in),
    .fq_i_change_pc(chg), .fq_i_alu_pc_value(tgt),
    .fq_i_flush(flush), .fq_i_stall(stall),
    .fq_o_valid(valid), .fq_o_instr(instr_o), .fq_o_pc(pc_o),
    .fq_o_opcode(opcode), .fq_o_addr_rd(rd), .fq_o_funct3(f3),
    .fq_o_addr_rs1(rs1), .fq_o_addr_rs2(rs2), .fq_o_count(cnt)
  );

  fetch_queue_front #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .fq_clk(clk), .fq_rst(rst_n),
    .fq_o_imem_req(w_req), .fq_o_imem_addr(w_addr),
    .fq_i_imem_ack(w_ack), .fq_i_imem_instr(w_instr),
    .fq_i_change_pc(w_zero), .fq_i_alu_pc_value(w_zero32),
    .fq_i_flush(w_zero), .fq_i_stall(w_stall),
    .fq_o_valid(w_valid), .fq_o_instr(w_instr_o), .fq_o_pc(w_pc_o),
    .fq_o_opcode(w_opcode), .fq_o_addr_rd(w_rd), .fq_o_funct3(w_f3),
    .fq_o_addr_rs1(w_rs1), .fq_o_addr_rs2(w_rs2), .fq_o_count(w_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: a scrambled function of the address so fields vary.
  function automatic logic [31:0] ifun(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_addr;
  bit          m_busy, m_drop;
  logic [31:0] m_q[$];
  int          lat, wait_cnt;
  bit          spurious, force_ack;

  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_busy = 0; m_drop = 0;
    m_q.delete(); wait_cnt = 0;
  endtask

  task automatic model_step(input bit a, input bit s, input bit c, input logic [31:0] t,
                            input bit f);
    bit kill;
    bit deliver;
    int n;
    kill = c | f;
    deliver = 0;
    n = m_q.size();
    if (m_busy) begin
      if (a) begin
        deliver = !m_drop && !kill;
        m_busy = 0;
        m_drop = 0;
      end else if (kill) begin
        m_drop = 1;
      end
    end else if (!kill && n < QD) begin
      m_busy = 1;
      m_addr = m_pc;
      m_drop = 0;
    end
    if (kill) begin
      m_q.delete();
      if (c) m_pc = t;
    end else begin
      if (n > 0 && !s) void'(m_q.pop_front());
      if (deliver) begin
        m_q.push_back(m_addr);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_model();
    logic [31:0] hp, hi;
    hp = '0; hi = '0;
    if (m_q.size() > 0) begin
      hp = m_q[0];
      hi = ifun(hp);
    end
    check("req", {31'b0, req}, {31'b0, m_busy});
    if (m_busy) check("addr", addr, m_addr);
    check("count", {29'b0, cnt}, m_q.size());
    check("valid", {31'b0, valid}, {31'b0, m_q.size() != 0});
    check("head_pc", pc_o, hp);
    check("head_instr", instr_o, hi);
    check("opcode", {25'b0, opcode}, {25'b0, hi[6:0]});
    check("rd", {27'b0, rd}, {27'b0, hi[11:7]});
    check("funct3", {29'b0, f3}, {29'b0, hi[14:12]});
    check("rs1", {27'b0, rs1}, {27'b0, hi[19:15]});
    check("rs2", {27'b0, rs2}, {27'b0, hi[24:20]});
  endtask

  // One clock: compare, drive inputs (memory stub answers per lat), advance model.
  task automatic step_cycle(input bit s, input bit c, input logic [31:0] t, input bit f);
    bit a;
    compare_model();
    a = 0;
    if (force_ack) begin
      a = 1;
    end else if (m_busy) begin
      if (wait_cnt >= lat) begin
        a = 1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else if (spurious) begin
      a = ($urandom_range(0, 7) == 0);
    end
    ack = a;
    instr_in = a ? ifun(m_addr) : $urandom;
    stall = s; chg = c; tgt = t; flush = f;
    model_step(a, s, c, t, f);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ack = 0; chg = 0; flush = 0; stall = 0; tgt = '0; instr_in = '0;
    w_ack = 0; w_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_count", {29'b0, cnt}, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          a, c, f, s;
    logic [31:0] t;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(bit a, bit c, bit f, bit s, logic [31:0] t, bit er,
                              logic [31:0] ea, bit ev, logic [31:0] ep, int ec);
    vec_t v;
    v.a = a; v.c = c; v.f = f; v.s = s; v.t = t;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    logic [31:0] hi;
    bit found;
    int nreq;
    logic [31:0] wa[2];
    bit prev_first;

    //          ack chg fl st tgt        req addr     val pc       cnt
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   0);
    tbl[1]  = mk(1, 0, 0, 0, 32'h0,    1, 32'h0,   0, 32'h0,   0);
    tbl[2]  = mk(0, 0, 0, 1, 32'h0,    0, 32'h0,   1, 32'h0,   1);
    tbl[3]  = mk(1, 0, 0, 1, 32'h0,    1, 32'h4,   1, 32'h0,   1);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0,    0, 32'h0,   1, 32'h0,   2);
    tbl[5]  = mk(0, 1, 0, 1, 32'h200,  1, 32'h8,   1, 32'h4,   1);
    tbl[6]  = mk(0, 0, 0, 0, 32'h0,    1, 32'h8,   0, 32'h0,   0);
    tbl[7]  = mk(1, 0, 0, 0, 32'h0,    1, 32'h8,   0, 32'h0,   0);
    tbl[8]  = mk(0, 0, 0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   0);
    tbl[9]  = mk(1, 0, 0, 0, 32'h0,    1, 32'h200, 0, 32'h0,   0);
    tbl[10] = mk(0, 0, 0, 1, 32'h0,    0, 32'h0,   1, 32'h200, 1);
    tbl[11] = mk(1, 0, 1, 1, 32'h0,    1, 32'h204, 1, 32'h200, 1);
    tbl[12] = mk(0, 0, 0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   0);
    tbl[13] = mk(1, 0, 0, 0, 32'h0,    1, 32'h204, 0, 32'h0,   0);
    tbl[14] = mk(0, 0, 0, 1, 32'h0,    0, 32'h0,   1, 32'h204, 1);

    w_zero = 1'b0; w_zero32 = '0; w_stall = 1'b0;
    lat = 0; spurious = 0; force_ack = 0;

    do_reset();
    for (int i = 0; i < 15; i++) begin
      hi = tbl[i].e_valid ? ifun(tbl[i].e_pc) : 32'h0;
      check($sformatf("tbl%0d_req", i), {31'b0, req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) check($sformatf("tbl%0d_addr", i), addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].e_valid});
      check($sformatf("tbl%0d_pc", i), pc_o, tbl[i].e_pc);
      check($sformatf("tbl%0d_instr", i), instr_o, hi);
      check($sformatf("tbl%0d_count", i), {29'b0, cnt}, tbl[i].e_cnt);
      ack = tbl[i].a; chg = tbl[i].c; flush = tbl[i].f; stall = tbl[i].s;
      tgt = tbl[i].t;
      instr_in = tbl[i].a ? ifun(tbl[i].e_addr) : 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
    end

    // Fill and stall, then drain four consecutive entries.
    do_reset();
    repeat (20) step_cycle(1, 0, 32'h0, 0);
    check("fill_count", {29'b0, cnt}, 32'd4);
    check("fill_req", {31'b0, req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'b0, valid}, 32'd1);
      check("drain_pc", pc_o, 32'(i * 4));
      step_cycle(0, 0, 32'h0, 0);
    end

    // Redirect while idle with three entries queued.
    do_reset();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_q.size() == 3 && !m_busy) begin
        found = 1;
        break;
      end
      step_cycle(1, 0, 32'h0, 0);
    end
    check("fill3_reached", {31'b0, found}, 32'd1);
    step_cycle(1, 1, 32'h100, 0);
    check("redir_count", {29'b0, cnt}, 32'd0);
    check("redir_valid", {31'b0, valid}, 32'd0);
    step_cycle(1, 0, 32'h0, 0);
    check("redir_req", {31'b0, req}, 32'd1);
    check("redir_addr", addr, 32'h100);

    // PC wrap on the second instance.
    do_reset();
    nreq = 0;
    prev_first = 0;
    for (int i = 0; i < 12; i++) begin
      if (prev_first) check("wrap_head_pc", w_pc_o, 32'hFFFF_FFFC);
      prev_first = 0;
      w_ack = 1'b0;
      if (w_req && nreq < 2) begin
        wa[nreq] = w_addr;
        w_ack = 1'b1;
        w_instr = ifun(w_addr);
        prev_first = (nreq == 0);
        nreq++;
      end
      step_cycle(0, 0, 32'h0, 0);
    end
    w_ack = 1'b0;
    check("wrap_nreq", nreq, 32'd2);
    if (nreq == 2) begin
      check("wrap_addr0", wa[0], 32'hFFFF_FFFC);
      check("wrap_addr1", wa[1], 32'h0);
    end

    // Randomised run against the model.
    do_reset();
    spurious = 1;
    for (int i = 0; i < 800; i++) begin
      bit s, c, f;
      s = ($urandom_range(0, 9) < 4);
      c = ($urandom_range(0, 24) == 0);
      f = ($urandom_range(0, 24) == 0);
      if (!m_busy) lat = $urandom_range(0, 3);
      step_cycle(s, c, $urandom & 32'hFFFF_FFFC, f);
    end
    spurious = 0;

    // Asynchronous reset in the middle of an outstanding request.
    lat = 5;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_busy && m_q.size() > 0) begin
        found = 1;
        break;
      end
      step_cycle(1, 0, 32'h0, 0);
    end
    check("midreq_reached", {31'b0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_req", {31'b0, req}, 32'd0);
    check("async_count", {29'b0, cnt}, 32'd0);
    check("async_valid", {31'b0, valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_reset();
    lat = 0;
    // A stale ack arriving in idle must be ignored.
    force_ack = 1;
    step_cycle(0, 0, 32'h0, 0);
    force_ack = 0;
    check("post_rst_addr", addr, 32'h0);
    repeat (10) step_cycle(0, 0, 32'h0, 0);
    compare_model();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
